// File: rtl/vga_pattern_sequencer.sv
// vga_pattern_sequencer: frame-synchronous VGA test-pattern stepper; define VGA_SEQ_BLANK_EN to insert one black frame on every advance
module vga_pattern_sequencer #(
    parameter int COLOR_BITS         = 3,
    parameter int ACTIVE_COLS        = 640,
    parameter int ACTIVE_ROWS        = 480,
    parameter int NUM_PATTERNS       = 8,
    parameter int FRAMES_PER_PATTERN = 60
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst_L,
    input  logic [9:0]            i_Col_Count,
    input  logic [9:0]            i_Row_Count,
    input  logic                  i_Next,
    input  logic                  i_Auto_En,
    output logic [COLOR_BITS-1:0] o_Red_Video,
    output logic [COLOR_BITS-1:0] o_Grn_Video,
    output logic [COLOR_BITS-1:0] o_Blu_Video,
    output logic [2:0]            o_Pattern_Sel,
    output logic                  o_Busy,
    output logic                  o_Frame_Start
);
    localparam logic [9:0]            AC       = 10'(ACTIVE_COLS);
    localparam logic [9:0]            AR       = 10'(ACTIVE_ROWS);
    localparam logic [9:0]            BAR_W    = 10'd80;
    localparam logic [2:0]            LAST     = 3'(NUM_PATTERNS - 1);
    localparam logic [7:0]            CNT_LAST = 8'(FRAMES_PER_PATTERN - 1);
    localparam logic [COLOR_BITS-1:0] F        = '1;

`ifdef VGA_SEQ_BLANK_EN
    typedef enum logic [1:0] {SHOW, PEND, BLANK} state_t;
    localparam state_t ADV_ST = BLANK;
`else
    typedef enum logic [1:0] {SHOW, PEND} state_t;
    localparam state_t ADV_ST = SHOW;
`endif

    state_t                state, nxt_state;
    logic [2:0]            nxt_sel;
    logic [7:0]            cnt, nxt_cnt;
    logic                  fb, hit, adv, active, blank, border;
    logic [9:0]            bar_idx;
    logic [2:0]            bar;
    logic [COLOR_BITS-1:0] red_d, grn_d, blu_d;

    assign fb     = (i_Col_Count == 10'd0) && (i_Row_Count == 10'd0);
    assign hit    = i_Auto_En && fb && (cnt == CNT_LAST);
    assign active = (i_Col_Count < AC) && (i_Row_Count < AR);
`ifdef VGA_SEQ_BLANK_EN
    assign blank  = (nxt_state == BLANK);
`else
    assign blank  = 1'b0;
`endif

    // state, pattern index, frame counter and registered video
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state         <= SHOW;
            o_Pattern_Sel <= 3'd0;
            cnt           <= 8'd0;
            o_Red_Video   <= '0;
            o_Grn_Video   <= '0;
            o_Blu_Video   <= '0;
            o_Frame_Start <= 1'b0;
        end else begin
            state         <= nxt_state;
            o_Pattern_Sel <= nxt_sel;
            cnt           <= nxt_cnt;
            o_Red_Video   <= red_d;
            o_Grn_Video   <= grn_d;
            o_Blu_Video   <= blu_d;
            o_Frame_Start <= fb;
        end
    end

    // advance decision: requests latch in SHOW, apply only at a frame boundary; an auto hit applies at once and absorbs a coincident request
    always_comb begin
        nxt_state = state;
        adv       = 1'b0;
        case (state)
            SHOW: begin
                adv       = hit;
                nxt_state = hit ? ADV_ST : (i_Next ? PEND : SHOW);
            end
            PEND: begin
                adv       = fb;
                nxt_state = fb ? ADV_ST : PEND;
            end
`ifdef VGA_SEQ_BLANK_EN
            BLANK: begin
                adv       = hit;
                nxt_state = (fb && !hit) ? SHOW : BLANK;
            end
`endif
            default: nxt_state = SHOW;
        endcase
        nxt_sel = adv ? ((o_Pattern_Sel == LAST) ? 3'd0 : o_Pattern_Sel + 3'd1) : o_Pattern_Sel;
        nxt_cnt = !i_Auto_En ? 8'd0 : !fb ? cnt : adv ? 8'd0 : cnt + 8'd1;
    end

    // pixel colour from the pattern that will be showing after this edge
    always_comb begin
        bar_idx = i_Col_Count / BAR_W;
        bar     = (bar_idx > 10'd7) ? 3'd7 : bar_idx[2:0];
        border  = (i_Col_Count < 10'd2) || (i_Row_Count < 10'd2) ||
                  (i_Col_Count >= AC - 10'd2) || (i_Row_Count >= AR - 10'd2);
        red_d   = '0;
        grn_d   = '0;
        blu_d   = '0;
        case (nxt_sel)
            3'd1: {red_d, grn_d, blu_d} = border ? {3{F}} : '0;
            3'd2: red_d = F;
            3'd3: grn_d = F;
            3'd4: blu_d = F;
            3'd5: {red_d, grn_d, blu_d} = (i_Col_Count[5] ^ i_Row_Count[5]) ? {3{F}} : '0;
            3'd6: begin
                red_d = bar[2] ? F : '0;
                grn_d = bar[1] ? F : '0;
                blu_d = bar[0] ? F : '0;
            end
            3'd7: {red_d, grn_d, blu_d} = {3{F}};
            default: ;
        endcase
        if (!active || blank) {red_d, grn_d, blu_d} = '0;
        o_Busy = (state != SHOW);
    end
endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// tb_vga_pattern_sequencer: scoreboard bench for vga_pattern_sequencer driving a sparse raster of probe pixels
module tb_vga_pattern_sequencer;
    localparam int FPP = 3;
    localparam int NP  = 8;
`ifdef VGA_SEQ_BLANK_EN
    localparam bit BL = 1'b1;
`else
    localparam bit BL = 1'b0;
`endif

    typedef struct {
        logic [2:0] r, g, b, sel;
        logic       busy, fs;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n, nx, ae;
    logic [9:0] col, row;
    logic [2:0] red, grn, blu, sel;
    logic       busy, fs;

    int   total = 0;
    int   bad   = 0;
    exp_t q[$];
    int   m_sel, m_st, m_cnt;

    int pc[12] = '{100, 300, 250, 700, 639, 640, 10, 1, 32, 637, 550, 120};
    int pr[12] = '{50, 200, 100, 100, 479, 10, 480, 1, 32, 300, 300, 50};

    vga_pattern_sequencer #(.FRAMES_PER_PATTERN(FPP)) dut (
        .i_Clk(clk), .i_Rst_L(rst_n), .i_Col_Count(col), .i_Row_Count(row),
        .i_Next(nx), .i_Auto_En(ae), .o_Red_Video(red), .o_Grn_Video(grn),
        .o_Blu_Video(blu), .o_Pattern_Sel(sel), .o_Busy(busy), .o_Frame_Start(fs)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [8:0] pix(input int s, input int c, input int r);
        int b;
        if (c >= 640 || r >= 480) return 9'd0;
        case (s)
            1: return (c < 2 || r < 2 || c >= 638 || r >= 478) ? 9'h1ff : 9'd0;
            2: return 9'b111_000_000;
            3: return 9'b000_111_000;
            4: return 9'b000_000_111;
            5: return ((((c / 32) + (r / 32)) % 2) == 1) ? 9'h1ff : 9'd0;
            6: begin
                b = c / 80;
                return {(b >= 4) ? 3'd7 : 3'd0, (((b / 2) % 2) == 1) ? 3'd7 : 3'd0, ((b % 2) == 1) ? 3'd7 : 3'd0};
            end
            7: return 9'h1ff;
            default: return 9'd0;
        endcase
    endfunction

    task automatic model(input int c, input int r, input logic n, output exp_t e);
        bit fb, hit, adv;
        logic [8:0] p;
        if (!rst_n) begin
            m_sel = 0; m_st = 0; m_cnt = 0;
            e.r = 0; e.g = 0; e.b = 0; e.sel = 0; e.busy = 0; e.fs = 0;
            return;
        end
        fb  = (c == 0 && r == 0);
        hit = ae && fb && (m_cnt == FPP - 1);
        adv = 0;
        if (m_st == 2) begin
            if (fb) begin
                if (hit) adv = 1;
                else m_st = 0;
            end
        end else if (fb && (m_st == 1 || hit)) adv = 1;
        else if (n && m_st == 0) m_st = 1;
        if (adv) begin
            m_sel = (m_sel + 1) % NP;
            m_st  = BL ? 2 : 0;
        end
        if (!ae) m_cnt = 0;
        else if (fb) m_cnt = adv ? 0 : m_cnt + 1;
        p = (m_st == 2) ? 9'd0 : pix(m_sel, c, r);
        e.r = p[8:6]; e.g = p[5:3]; e.b = p[2:0];
        e.sel = 3'(m_sel); e.busy = (m_st != 0); e.fs = fb;
    endtask

    task automatic drive(input int c, input int r, input logic n);
        exp_t e;
        col = 10'(c); row = 10'(r); nx = n;
        model(c, r, n, e);
        q.push_back(e);
        @(negedge clk);
        if (q.size() == 0) begin
            chk("sb_empty", 1, 0);
        end else begin
            e = q.pop_front();
            chk("red", 32'(red), 32'(e.r));
            chk("grn", 32'(grn), 32'(e.g));
            chk("blu", 32'(blu), 32'(e.b));
            chk("sel", 32'(sel), 32'(e.sel));
            chk("busy", 32'(busy), 32'(e.busy));
            chk("fstart", 32'(fs), 32'(e.fs));
        end
        nx = 1'b0;
    endtask

    task automatic body(input logic [11:0] mask);
        for (int i = 0; i < 12; i++) drive(pc[i], pr[i], mask[i]);
    endtask

    task automatic frame(input logic [11:0] mask);
        drive(0, 0, 1'b0);
        body(mask);
    endtask

    task automatic to_new();
        drive(0, 0, 1'b0);
`ifdef VGA_SEQ_BLANK_EN
        body(12'h000);
        drive(0, 0, 1'b0);
`endif
    endtask

    task automatic advance();
        frame(12'h001);
        to_new();
        body(12'h000);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; nx = 1'b0; ae = 1'b0; col = 10'd5; row = 10'd5;
        m_sel = 0; m_st = 0; m_cnt = 0;
        @(negedge clk);
        drive(5, 5, 1'b0);
        drive(5, 5, 1'b0);
        rst_n = 1'b1;
        frame(12'h000);
        repeat (5) advance();
        chk("pre_rst_sel", 32'(sel), 5);
        drive(0, 0, 1'b0);
        drive(300, 200, 1'b1);
        chk("pre_rst_pix", 32'(red), 7);
        chk("pre_rst_busy", 32'(busy), 1);
        rst_n = 1'b0;
        drive(310, 200, 1'b0);
        drive(0, 0, 1'b0);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_vid", 32'({red, grn, blu}), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_fstart", 32'(fs), 0);
        rst_n = 1'b1;
        body(12'h000);
        frame(12'h000);
        chk("no_stale_adv", 32'(sel), 0);
        drive(0, 0, 1'b0);
        drive(100, 50, 1'b1);
        chk("man_busy", 32'(busy), 1);
        chk("man_sel_hold", 32'(sel), 0);
        drive(300, 200, 1'b0);
        chk("man_sel_hold2", 32'(sel), 0);
        drive(0, 0, 1'b0);
        chk("man_sel_new", 32'(sel), 1);
`ifdef VGA_SEQ_BLANK_EN
        chk("blank_pix00", 32'({red, grn, blu}), 0);
        chk("blank_busy", 32'(busy), 1);
        drive(1, 1, 1'b0);
        chk("blank_pix11", 32'({red, grn, blu}), 0);
        body(12'h000);
        drive(0, 0, 1'b0);
`endif
        chk("border_pix00", 32'({red, grn, blu}), 32'h1ff);
        chk("man_busy_done", 32'(busy), 0);
        body(12'h000);
        frame(12'h803);
        to_new();
        drive(300, 200, 1'b0);
        chk("coal_sel", 32'(sel), 2);
        chk("coal_pix", 32'({red, grn, blu}), 32'h1c0);
        body(12'h000);
        repeat (4) advance();
        chk("bars_sel", 32'(sel), 6);
        drive(250, 100, 1'b0);
        chk("bar3_pix", 32'({red, grn, blu}), 32'h03f);
        drive(700, 100, 1'b0);
        chk("inactive_pix", 32'({red, grn, blu}), 0);
        advance();
        chk("sel7", 32'(sel), 7);
        advance();
        chk("wrap_sel", 32'(sel), 0);
        ae = 1'b1;
        repeat (2) frame(12'h000);
        drive(0, 0, 1'b1);
        chk("auto_fb3_sel", 32'(sel), 1);
        chk("auto_fb3_busy", 32'(busy), 32'(BL));
        body(12'h000);
        drive(0, 0, 1'b0);
        chk("auto_fb4_sel", 32'(sel), 1);
        body(12'h000);
        frame(12'h000);
        drive(0, 0, 1'b0);
        chk("auto_fb6_sel", 32'(sel), 2);
        body(12'h000);
        drive(0, 0, 1'b0);
        chk("auto_fb7_sel", 32'(sel), 2);
        ae = 1'b0;
        body(12'h000);
        frame(12'h000);
        chk("sb_drained", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
